tpu_cfu_driver: RTL and testbench
=================================

Name: tpu_cfu_driver

Overview:
- Hardware initiator for the TPU CFU command/response interface. It plays the CPU side of the same protocol.
- Accepts one GEMM job descriptor and issues the full CFU command sequence: reset, set K/M/N, load buffers A and B, start, poll busy, read C.
- Streams the C results out on a valid/ready port.
- Used for CPU-less bring-up and as the stimulus engine in CFU regression benches.

Parameters:
- ADDR_BITS, 8, global buffer index width; word counters are ADDR_BITS+1 bits.
- POLL_LIMIT, 4096, maximum number of op-13 busy polls before the job aborts with an error.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- job_valid  in  1  job descriptor valid
- job_ready  out  1  high only in IDLE
- job_k / job_m / job_n  in  32 each  matrix parameters, forwarded verbatim
- job_a_words / job_b_words  in  ADDR_BITS+1 each  number of A / B words to load
- job_c_rows  in  ADDR_BITS+1  number of C indices to read back
- src_valid  in  1  A/B word available
- src_ready  out  1  A/B word consumed
- src_data  in  32  A words first, then B words, same stream
- res_valid  out  1  C word valid
- res_ready  in  1  C word accepted
- res_data  out  32  C word
- done  out  1  one-cycle pulse at job end
- err  out  1  sticky poll-timeout flag; cleared on next job accept
- cmd_valid  out  1  to CFU
- cmd_ready  in  1  from CFU
- cmd_payload_function_id  out  10  {op[6:0], 3'b000}
- cmd_payload_inputs_0  out  32  to CFU
- cmd_payload_inputs_1  out  32  to CFU
- rsp_valid  in  1  from CFU
- rsp_ready  out  1  to CFU
- rsp_payload_outputs_0  in  32  from CFU

Behaviour:
- Reset values: cmd_valid, rsp_ready, src_ready, res_valid, done and err are 0; job_ready is 1; payload outputs are 0; FSM is in IDLE.
- Bus engine: one command outstanding at a time.
  - ISSUE: drive cmd_valid=1 with a stable payload until cmd_valid&&cmd_ready is sampled at posedge. Next cycle cmd_valid=0 and rsp_ready=1.
  - WAIT_RSP: on rsp_valid&&rsp_ready, capture rsp_payload_outputs_0 and drop rsp_ready next cycle.
  - Every command, including writes, waits for its response before the next command is issued.
- Command sequence, with each entry as op: inputs_0, inputs_1:
  - 1: 0, 0 (reset pulse)
  - 2: K
  - 4: M
  - 6: N
  - 8: idx, src word — repeated for idx = 0 .. a_words-1
  - 10: idx, src word — repeated for idx = 0 .. b_words-1
  - 12 (start)
  - 13, repeated until the response bit 0 == 0
  - 14, 15, 16, 17: idx — for each idx = 0 .. c_rows-1
- Unused inputs are driven 0.
- Source stream handling: an A/B word is taken (src_ready=1 for exactly that cycle) only when src_valid=1 and the engine is ready to issue. The word is then held in the payload register. If src_valid=0, wait with cmd_valid=0.
- Result stream handling: each C-read response enters PUSH with res_valid=1 and res_data = the captured value. The next command is not issued until res_ready=1.
  - Word order per idx: bits [31:0], [63:32], [95:64], [127:96].
- Zero counts: a_words=0 skips the op-8 phase, b_words=0 skips op-10, c_rows=0 skips the read phase. Counters compare with ==, so there is no wrap.
- Poll timeout: the poll counter increments per op-13 response. If POLL_LIMIT responses all return busy=1, set err=1, skip the C reads, pulse done, and return to IDLE.
- Job accept: job_valid&&job_ready latches all job fields and clears err. The descriptor is then ignored until IDLE.
- done: asserted one cycle on entry to IDLE from an active job.
- Reset mid-job: all outputs return to reset values on the next edge, including cmd_valid=0 with a handshake pending. Resetting the CFU alongside is the system's responsibility.
- cmd_ready while cmd_valid=0 is ignored. rsp_valid outside WAIT_RSP is ignored.

Test Plan:
- K=M=N=4, a_words=b_words=4 with A[i]=0x01020304+i and B[i]=0x10+i, c_rows=4, CFU model with busy=1 for 5 polls -> exact op/input sequence: 1, 2, 4, 6, 8×4, 10×4, 12, 13×6, then 14–17×4; 16 res words in order; one done pulse; err=0.
- src_valid low for 7 cycles mid-A-load -> cmd_valid stays 0 during the gap; no index skipped or duplicated; A[2] is issued with inputs_0=2.
- res_ready low for 10 cycles after the first C word -> res_valid and res_data are held; no op-15 command is issued until acceptance.
- CFU model that never clears busy, POLL_LIMIT=8 -> exactly 8 op-13 commands, then err=1, done pulse, no op-14 issued, job_ready=1.
- a_words=0, b_words=0, c_rows=0 -> sequence is 1, 2, 4, 6, 12, 13(busy=0), then done; no src_ready or res_valid activity.
- reset asserted while cmd_valid=1 waiting on cmd_ready -> next cycle cmd_valid=0 and job_ready=1; a new job then runs correctly from op 1.

Source files
------------

// File: rtl/tpu_cfu_driver_if.sv
// CFU command/response bus between an initiator (master) and the TPU CFU (slave).
interface tpu_cfu_driver_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;

    modport master (
        output cmd_valid, cmd_payload_function_id,
        output cmd_payload_inputs_0, cmd_payload_inputs_1,
        output rsp_ready,
        input  cmd_ready, rsp_valid, rsp_payload_outputs_0
    );

    modport slave (
        input  cmd_valid, cmd_payload_function_id,
        input  cmd_payload_inputs_0, cmd_payload_inputs_1,
        input  rsp_ready,
        output cmd_ready, rsp_valid, rsp_payload_outputs_0
    );
endinterface

// File: rtl/tpu_cfu_driver.sv
// Hardware CFU initiator: runs one GEMM job through the CFU command sequence
// and streams the C words out.
module tpu_cfu_driver #(
    parameter int ADDR_BITS  = 8,
    parameter int POLL_LIMIT = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [31:0]          job_k,
    input  logic [31:0]          job_m,
    input  logic [31:0]          job_n,
    input  logic [ADDR_BITS:0]   job_a_words,
    input  logic [ADDR_BITS:0]   job_b_words,
    input  logic [ADDR_BITS:0]   job_c_rows,
    input  logic                 src_valid,
    output logic                 src_ready,
    input  logic [31:0]          src_data,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_data,
    output logic                 done,
    output logic                 err,
    tpu_cfu_driver_if.master     bus
);
    localparam int PW = $clog2(POLL_LIMIT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_NEXT, S_FETCH, S_ISSUE, S_WAIT, S_PUSH
    } state_t;

    typedef enum logic [3:0] {
        P_RST, P_K, P_M, P_N, P_A, P_B, P_START, P_POLL, P_C
    } phase_t;

    state_t             state;
    phase_t             phase;
    logic [31:0]        k, m, n;
    logic [ADDR_BITS:0] a_words, b_words, c_rows, cnt;
    logic [1:0]         sub;
    logic [PW-1:0]      polls;
    logic [6:0]         op;
    logic [31:0]        in0, in1;
    logic               cmd_valid, rsp_ready;

    assign bus.cmd_valid               = cmd_valid;
    assign bus.rsp_ready               = rsp_ready;
    assign bus.cmd_payload_function_id = {op, 3'b000};
    assign bus.cmd_payload_inputs_0    = in0;
    assign bus.cmd_payload_inputs_1    = in1;

    // A/B word is consumed in the same cycle the engine latches it.
    assign src_ready = (state == S_FETCH) && src_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            phase     <= P_RST;
            job_ready <= 1'b1;
            cmd_valid <= 1'b0;
            rsp_ready <= 1'b0;
            op        <= '0;
            in0       <= '0;
            in1       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            k         <= '0;
            m         <= '0;
            n         <= '0;
            a_words   <= '0;
            b_words   <= '0;
            c_rows    <= '0;
            cnt       <= '0;
            sub       <= '0;
            polls     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (job_valid) begin
                        k         <= job_k;
                        m         <= job_m;
                        n         <= job_n;
                        a_words   <= job_a_words;
                        b_words   <= job_b_words;
                        c_rows    <= job_c_rows;
                        err       <= 1'b0;
                        job_ready <= 1'b0;
                        phase     <= P_RST;
                        cnt       <= '0;
                        state     <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    in0 <= '0;
                    in1 <= '0;
                    unique case (phase)
                        P_RST: begin
                            op <= 7'd1; cmd_valid <= 1'b1; state <= S_ISSUE;
                        end
                        P_K: begin
                            op <= 7'd2; in0 <= k; cmd_valid <= 1'b1; state <= S_ISSUE;
                        end
                        P_M: begin
                            op <= 7'd4; in0 <= m; cmd_valid <= 1'b1; state <= S_ISSUE;
                        end
                        P_N: begin
                            op <= 7'd6; in0 <= n; cmd_valid <= 1'b1; state <= S_ISSUE;
                        end
                        P_A: begin
                            if (cnt == a_words) begin
                                phase <= P_B;
                                cnt   <= '0;
                            end else begin
                                state <= S_FETCH;
                            end
                        end
                        P_B: begin
                            if (cnt == b_words) phase <= P_START;
                            else state <= S_FETCH;
                        end
                        P_START: begin
                            op <= 7'd12; cmd_valid <= 1'b1; state <= S_ISSUE;
                        end
                        P_POLL: begin
                            op <= 7'd13; cmd_valid <= 1'b1; state <= S_ISSUE;
                        end
                        P_C: begin
                            if (cnt == c_rows) begin
                                done      <= 1'b1;
                                job_ready <= 1'b1;
                                state     <= S_IDLE;
                            end else begin
                                op        <= 7'd14 + {5'd0, sub};
                                in0       <= 32'(cnt);
                                cmd_valid <= 1'b1;
                                state     <= S_ISSUE;
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
                S_FETCH: begin
                    if (src_valid) begin
                        op        <= (phase == P_A) ? 7'd8 : 7'd10;
                        in0       <= 32'(cnt);
                        in1       <= src_data;
                        cmd_valid <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.cmd_ready) begin
                        cmd_valid <= 1'b0;
                        rsp_ready <= 1'b1;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.rsp_valid) begin
                        rsp_ready <= 1'b0;
                        state     <= S_NEXT;
                        unique case (phase)
                            P_RST: phase <= P_K;
                            P_K:   phase <= P_M;
                            P_M:   phase <= P_N;
                            P_N: begin
                                phase <= P_A;
                                cnt   <= '0;
                            end
                            P_A, P_B: cnt <= cnt + 1'b1;
                            P_START: begin
                                phase <= P_POLL;
                                polls <= '0;
                            end
                            P_POLL: begin
                                if (!bus.rsp_payload_outputs_0[0]) begin
                                    phase <= P_C;
                                    cnt   <= '0;
                                    sub   <= '0;
                                end else if (polls == PW'(POLL_LIMIT - 1)) begin
                                    err       <= 1'b1;
                                    done      <= 1'b1;
                                    job_ready <= 1'b1;
                                    state     <= S_IDLE;
                                end else begin
                                    polls <= polls + 1'b1;
                                end
                            end
                            P_C: begin
                                res_valid <= 1'b1;
                                res_data  <= bus.rsp_payload_outputs_0;
                                state     <= S_PUSH;
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
                S_PUSH: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        sub       <= sub + 1'b1;
                        if (sub == 2'd3) cnt <= cnt + 1'b1;
                        state     <= S_NEXT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tpu_cfu_driver.sv
// Randomized bench for tpu_cfu_driver against a CFU model and a
// job-level expected command/result sequence.
module tb_tpu_cfu_driver;
    localparam int AB = 8;
    localparam int PL = 8;

    typedef struct packed {
        logic [9:0]  fid;
        logic [31:0] a;
        logic [31:0] b;
    } cmd_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          job_valid = 1'b0;
    logic          job_ready;
    logic [31:0]   job_k = '0, job_m = '0, job_n = '0;
    logic [AB:0]   job_a_words = '0, job_b_words = '0, job_c_rows = '0;
    logic          src_valid, src_ready;
    logic [31:0]   src_data;
    logic          res_valid, res_ready;
    logic [31:0]   res_data;
    logic          done, err;

    tpu_cfu_driver_if bus();

    tpu_cfu_driver #(.ADDR_BITS(AB), .POLL_LIMIT(PL)) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_k(job_k), .job_m(job_m), .job_n(job_n),
        .job_a_words(job_a_words), .job_b_words(job_b_words),
        .job_c_rows(job_c_rows),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .done(done), .err(err), .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cword(input int idx, input int w);
        return 32'hC0DE0000 + 32'(idx * 16 + w);
    endfunction

    // Job configuration, written only by the stimulus process.
    logic [31:0] src_words[$];
    int  busy_cfg = 0;
    bit  never_clear = 0;
    bit  hold_cmd = 0;
    bit  res_hold = 0;
    int  gap_at = -1;
    int  gap_len = 0;
    int  gap_rel = 0;

    // Posedge monitor.
    cmd_t        cmd_q[$];
    logic [31:0] res_q[$];
    int          done_cnt = 0, src_idx = 0, cmd_cnt = 0, rsp_cnt = 0;
    logic [6:0]  lc_op = '0;
    logic [31:0] lc_a = '0;

    always @(posedge clk) begin
        if (!reset) begin
            if (bus.cmd_valid && bus.cmd_ready) begin
                cmd_q.push_back({bus.cmd_payload_function_id,
                                 bus.cmd_payload_inputs_0,
                                 bus.cmd_payload_inputs_1});
                lc_op = bus.cmd_payload_function_id[9:3];
                lc_a  = bus.cmd_payload_inputs_0;
                cmd_cnt++;
            end
            if (bus.rsp_valid && bus.rsp_ready) rsp_cnt++;
            if (res_valid && res_ready) res_q.push_back(res_data);
            if (done) done_cnt++;
            if (src_valid && src_ready) src_idx++;
        end
    end

    // CFU, source and sink models, driven away from the active edge.
    int          cmd_seen = 0, rsp_seen = 0, poll_seen = 0, dly = 0;
    int          gap_cnt = 0, gap_prev = -1, gap_viol = 0;
    bit          pend = 0;
    logic [31:0] pend_word = '0;

    always @(negedge clk) begin
        if (reset) begin
            bus.cmd_ready = 1'b0;
            bus.rsp_valid = 1'b0;
            bus.rsp_payload_outputs_0 = '0;
            pend = 0;
            cmd_seen = cmd_cnt;
            rsp_seen = rsp_cnt;
            src_valid = 1'b0;
            src_data = '0;
            res_ready = 1'b0;
        end else begin
            if (rsp_cnt != rsp_seen) begin
                rsp_seen = rsp_cnt;
                bus.rsp_valid = 1'b0;
            end
            if (cmd_cnt != cmd_seen) begin
                cmd_seen = cmd_cnt;
                pend = 1;
                dly = $urandom_range(0, 2);
                bus.cmd_ready = 1'b0;
                pend_word = $urandom;
                if (lc_op == 7'd1) poll_seen = 0;
                if (lc_op == 7'd13) begin
                    pend_word[0] = never_clear || (poll_seen < busy_cfg);
                    poll_seen++;
                end else if (lc_op >= 7'd14 && lc_op <= 7'd17) begin
                    pend_word = cword(int'(lc_a), int'(lc_op) - 14);
                end
            end
            if (pend) begin
                if (dly == 0) begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_payload_outputs_0 = pend_word;
                    pend = 0;
                end else begin
                    dly--;
                end
            end else if (!bus.rsp_valid) begin
                bus.cmd_ready = !hold_cmd && ($urandom_range(0, 2) != 0);
            end
            if (src_idx != gap_prev) begin
                gap_prev = src_idx;
                gap_cnt = 0;
            end
            if (src_idx == gap_at && gap_cnt < gap_len) begin
                src_valid = 1'b0;
                gap_cnt++;
                if (bus.cmd_valid && bus.cmd_payload_function_id == 10'd64
                    && bus.cmd_payload_inputs_0 == 32'(gap_rel))
                    gap_viol++;
            end else if (src_idx < src_words.size()
                         && $urandom_range(0, 3) != 0) begin
                src_valid = 1'b1;
                src_data = src_words[src_idx];
            end else begin
                src_valid = 1'b0;
            end
            res_ready = !res_hold && ($urandom_range(0, 3) != 0);
        end
    end

    logic [31:0] j_k, j_m, j_n;
    int j_a, j_b, j_c, j_sb, cb, rb, db;

    function automatic int cnt_op(input int op);
        int c = 0;
        for (int i = cb; i < cmd_q.size(); i++)
            if (cmd_q[i].fid == 10'(op * 8)) c++;
        return c;
    endfunction

    task automatic start_job(input logic [31:0] k, m, n, input int a, b, c,
                             input int busy, input bit never, input bit fixed);
        j_k = k; j_m = m; j_n = n; j_a = a; j_b = b; j_c = c;
        busy_cfg = busy;
        never_clear = never;
        j_sb = src_idx;
        for (int i = 0; i < a; i++)
            src_words.push_back(fixed ? 32'h01020304 + 32'(i) : $urandom);
        for (int i = 0; i < b; i++)
            src_words.push_back(fixed ? 32'h10 + 32'(i) : $urandom);
        cb = cmd_q.size();
        rb = res_q.size();
        db = done_cnt;
        @(negedge clk);
        chk("job_ready_idle", job_ready, 1);
        job_valid = 1'b1;
        job_k = k; job_m = m; job_n = n;
        job_a_words = 9'(a); job_b_words = 9'(b); job_c_rows = 9'(c);
        @(negedge clk);
        job_valid = 1'b0;
        job_k = $urandom;
        chk("job_ready_busy", job_ready, 0);
        chk("err_clear", err, 0);
    endtask

    task automatic finish_job(input string t);
        int   to = 0;
        int   np;
        cmd_t e[$];
        logic [31:0] r[$];
        while (done_cnt == db && to < 20000) begin
            @(negedge clk);
            to++;
        end
        chk({t, ".timeout"}, 32'(to < 20000), 1);
        repeat (2) @(negedge clk);
        chk({t, ".done_pulses"}, 32'(done_cnt - db), 1);
        chk({t, ".err"}, err, 32'(never_clear));
        chk({t, ".job_ready"}, job_ready, 1);
        chk({t, ".src_taken"}, 32'(src_idx - j_sb), 32'(j_a + j_b));
        e.push_back({10'd8, 32'd0, 32'd0});
        e.push_back({10'd16, j_k, 32'd0});
        e.push_back({10'd32, j_m, 32'd0});
        e.push_back({10'd48, j_n, 32'd0});
        for (int i = 0; i < j_a; i++)
            e.push_back({10'd64, 32'(i), src_words[j_sb + i]});
        for (int i = 0; i < j_b; i++)
            e.push_back({10'd80, 32'(i), src_words[j_sb + j_a + i]});
        e.push_back({10'd96, 32'd0, 32'd0});
        np = never_clear ? PL : busy_cfg + 1;
        for (int i = 0; i < np; i++) e.push_back({10'd104, 32'd0, 32'd0});
        if (!never_clear)
            for (int i = 0; i < j_c; i++)
                for (int w = 0; w < 4; w++) begin
                    e.push_back({10'(8 * (14 + w)), 32'(i), 32'd0});
                    r.push_back(cword(i, w));
                end
        chk({t, ".ncmd"}, 32'(cmd_q.size() - cb), 32'(e.size()));
        for (int i = 0; i < e.size() && cb + i < cmd_q.size(); i++) begin
            chk($sformatf("%s.cmd%0d.fid", t, i), 32'(cmd_q[cb + i].fid),
                32'(e[i].fid));
            chk($sformatf("%s.cmd%0d.in0", t, i), cmd_q[cb + i].a, e[i].a);
            chk($sformatf("%s.cmd%0d.in1", t, i), cmd_q[cb + i].b, e[i].b);
        end
        chk({t, ".nres"}, 32'(res_q.size() - rb), 32'(r.size()));
        for (int i = 0; i < r.size() && rb + i < res_q.size(); i++)
            chk($sformatf("%s.res%0d", t, i), res_q[rb + i], r[i]);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        int to;
        logic [31:0] held;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.cmd_valid", bus.cmd_valid, 0);
        chk("rst.rsp_ready", bus.rsp_ready, 0);
        chk("rst.src_ready", src_ready, 0);
        chk("rst.res_valid", res_valid, 0);
        chk("rst.done", done, 0);
        chk("rst.err", err, 0);
        chk("rst.job_ready", job_ready, 1);
        chk("rst.fid", 32'(bus.cmd_payload_function_id), 0);
        chk("rst.in0", bus.cmd_payload_inputs_0, 0);
        chk("rst.in1", bus.cmd_payload_inputs_1, 0);
        reset = 1'b0;

        start_job(4, 4, 4, 4, 4, 4, 5, 0, 1);
        finish_job("basic");

        gap_at = src_idx + 2;
        gap_len = 7;
        gap_rel = 2;
        start_job($urandom, $urandom, $urandom, 4, 2, 1, 1, 0, 0);
        finish_job("src_gap");
        chk("src_gap.viol", 32'(gap_viol), 0);
        gap_at = -1;

        res_hold = 1;
        start_job(2, 3, 4, 1, 1, 2, 0, 0, 0);
        to = 0;
        while (!res_valid && to < 5000) begin
            @(negedge clk);
            to++;
        end
        chk("hold.res_valid_seen", res_valid, 1);
        held = 32'hC0DE0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold.res_valid", res_valid, 1);
            chk("hold.res_data", res_data, held);
            chk("hold.cmd_valid", bus.cmd_valid, 0);
        end
        chk("hold.no_op15", 32'(cnt_op(15)), 0);
        res_hold = 0;
        finish_job("res_hold");

        start_job(9, 9, 9, 1, 1, 2, 0, 1, 0);
        finish_job("timeout");
        chk("timeout.op13", 32'(cnt_op(13)), PL);
        chk("timeout.no_op14", 32'(cnt_op(14)), 0);

        start_job(1, 1, 1, 0, 0, 0, 0, 0, 0);
        finish_job("zero");

        hold_cmd = 1;
        start_job(5, 6, 7, 0, 0, 0, 0, 0, 0);
        to = 0;
        while (!bus.cmd_valid && to < 100) begin
            @(negedge clk);
            to++;
        end
        chk("midrst.cmd_valid_pre", bus.cmd_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst.cmd_valid", bus.cmd_valid, 0);
        chk("midrst.job_ready", job_ready, 1);
        chk("midrst.rsp_ready", bus.rsp_ready, 0);
        reset = 1'b0;
        hold_cmd = 0;
        start_job(3, 2, 1, 2, 3, 1, 2, 0, 0);
        finish_job("after_rst");

        for (int t = 0; t < 6; t++) begin
            start_job($urandom, $urandom, $urandom, $urandom_range(0, 5),
                      $urandom_range(0, 5), $urandom_range(0, 3),
                      $urandom_range(0, 4), 0, 0);
            finish_job($sformatf("rand%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
